// File: rtl/product_accumulator_12x12_pkg.sv
// Shared definitions for the product accumulator codebase: controller state
// encoding, default widths and the signed saturation limits.
package product_accumulator_12x12_pkg;

  localparam int ACC_W_DEF = 32;
  localparam int CNT_W_DEF = 8;
  localparam int P_W       = 24;

  localparam logic [ACC_W_DEF-1:0] SAT_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
  localparam logic [ACC_W_DEF-1:0] SAT_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/product_accumulator_12x12_if.sv
// Product input stream and result output stream of the accumulator.
//   in_valid/in_ready/in_p/in_last : 24-bit signed product beats
//   out_valid/out_ready             : result handshake
//   out_sum/out_cnt/out_ovf         : saturated sum, term count, overflow flag
// master = producer/consumer side, slave = accumulator side.
interface product_accumulator_12x12_if
  import product_accumulator_12x12_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [P_W-1:0]   in_p;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ovf;

  modport master (
    output in_valid, in_p, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_cnt, out_ovf
  );

  modport slave (
    input  in_valid, in_p, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_cnt, out_ovf
  );
endinterface

// File: rtl/product_accumulator_12x12_sat_add_signed.sv
// Combinational W-bit two's-complement adder with saturation.
//   a, b : signed operands
//   y    : a+b clamped to [-2^(W-1), 2^(W-1)-1]
//   ovf  : high when clamping happened
module sat_add_signed #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y,
  output logic         ovf
);
  localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  logic [W:0] sum_ext;

  always_comb begin
    sum_ext = {a[W-1], a} + {b[W-1], b};
    // Overflow when the extra sign bit disagrees with the result sign bit;
    // the extra bit then holds the true sign of the sum.
    ovf = sum_ext[W] ^ sum_ext[W-1];
    if (ovf) y = sum_ext[W] ? MIN_V : MAX_V;
    else     y = sum_ext[W-1:0];
  end
endmodule

// File: rtl/product_accumulator_12x12.sv
// Streaming saturating accumulator behind the 12x12 multiplier.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous abort of partial sum and pending result
//   bus        : product input stream and registered result stream
//
// state | meaning
// ------+------------------------------------------
// ACCUM | collecting terms, in_ready high unless clr
// HOLD  | result presented, waiting for out_ready
module product_accumulator_12x12
  import product_accumulator_12x12_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  product_accumulator_12x12_if.slave bus
);
  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_ovf_q, out_ovf_d;

  logic [ACC_W-1:0] term_ext;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf_inc;
  logic             accept;

  assign term_ext = {{(ACC_W-P_W){bus.in_p[P_W-1]}}, bus.in_p};

  sat_add_signed #(.W(ACC_W)) u_sat_add (
    .a   (acc_q),
    .b   (term_ext),
    .y   (add_sum),
    .ovf (add_ovf)
  );

  assign bus.in_ready  = (state_q == ACCUM) && !clr;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cnt   = out_cnt_q;
  assign bus.out_ovf   = out_ovf_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cnt_d   = out_cnt_q;
    out_ovf_d   = out_ovf_q;

    accept  = bus.in_valid && bus.in_ready;
    cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    ovf_inc = ovf_q | add_ovf;

    if (clr) begin
      // Pending result is dropped even if out_ready is high this cycle.
      state_d     = ACCUM;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (accept) begin
            if (bus.in_last) begin
              out_sum_d   = add_sum;
              out_cnt_d   = cnt_inc;
              out_ovf_d   = ovf_inc;
              out_valid_d = 1'b1;
              state_d     = HOLD;
              acc_d       = '0;
              cnt_d       = '0;
              ovf_d       = 1'b0;
            end else begin
              acc_d = add_sum;
              cnt_d = cnt_inc;
              ovf_d = ovf_inc;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cnt_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cnt_q   <= out_cnt_d;
      out_ovf_q   <= out_ovf_d;
    end
  end
endmodule

// File: doc/product_accumulator_12x12.md
# product_accumulator_12x12

Streaming accumulator that sits directly downstream of the 12x12 radix-4 Booth/Wallace multiplier. It takes the multiplier's 24-bit two's-complement product P, one term per cycle, under a valid/ready handshake. It sums a vector of terms into a saturating 32-bit accumulator and presents the dot-product result, a term count and an overflow flag on a registered valid/ready output port. This turns the combinational multiplier into a MAC datapath usable for filter and dot-product work.

## Interface
- ACC_W, 32, accumulator and result width (must be > 24)
- CNT_W, 8, term-counter width
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock, asynchronous and active-low
- clr  input  1  synchronous abort: discard partial sum and any pending result
- in_valid  input  1  product beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_p  input  24  signed product from the multiplier
- in_last  input  1  beat is the final term of the vector
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  ACC_W  signed saturated sum
- out_cnt  output  CNT_W  number of terms in the vector, saturating at 2^CNT_W-1
- out_ovf  output  1  saturation occurred at least once in this vector

## Operation
- States: ACCUM (collecting terms), HOLD (result presented).
- Reset: state ACCUM, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_cnt=0, out_ovf=0.
- in_ready = (state==ACCUM) && !clr. A beat is accepted on in_valid && in_ready.
- Accepted beat: in_p is sign-extended to ACC_W and added to acc with signed saturation.
  - Positive overflow gives 2^(ACC_W-1)-1 and sets ovf.
  - Negative overflow gives -2^(ACC_W-1) and sets ovf.
  - ovf is sticky for the vector. Once acc is saturated, further terms keep adding to the saturated value with the same rule.
- cnt increments per accepted beat and stops at its maximum.
- Accepted beat with in_last=1: load out_sum, out_cnt and out_ovf from the post-add values. Set out_valid=1, go to HOLD, and reset acc, cnt and ovf to 0.
- HOLD: outputs are held stable until out_valid && out_ready, then out_valid=0 and state returns to ACCUM.
- clr=1, any state: next edge sets acc=0, cnt=0, ovf=0, out_valid=0 and state ACCUM. clr beats a simultaneous in_valid, so that beat is not accepted. clr beats a simultaneous out_ready; the result is dropped and counts as not delivered.
- Reset asserted mid-vector or in HOLD: immediate return to the reset values; the partial sum is lost.
- A vector always contains at least one term. A single beat with in_last=1 is a one-term vector.

## Timing
- Accumulate latency: one cycle per beat. Throughput is one term per cycle within a vector.
- Result latency: out_valid rises on the edge after the in_last beat is accepted.
- HOLD lasts at least one cycle. in_ready is low for that cycle, so there is one bubble between vectors. There is one more bubble for each cycle out_ready stays low.
- All outputs are registered except in_ready, which is combinational from state and clr.
- out_sum, out_cnt and out_ovf must not change while out_valid=1 and out_ready=0.

## Structure
- Shared package holds:
  - the state enum {ACCUM, HOLD}
  - the ACC_W and CNT_W defaults
  - the constants SAT_MAX = 2^(ACC_W-1)-1 and SAT_MIN = -2^(ACC_W-1)
- One sub-module, sat_add_signed: a combinational ACC_W-bit signed adder with saturation and an overflow output. It is reused wherever the codebase needs saturating sums.

## Test plan
- Products 100, -30, 7 (last on the third beat), out_ready=1 -> out_valid on the cycle after the third beat, out_sum=77, out_cnt=3, out_ovf=0, then in_ready=1 the following cycle.
- 511 beats of 0x400000 (2048*2048), last on beat 511 -> out_sum=2143289344, out_cnt=255 (saturated), out_ovf=0. The same stream with 512 beats -> out_sum=0x7FFFFFFF, out_ovf=1.
- 600 beats of 0xC00000 (-4194304) -> out_sum=0x80000000, out_ovf=1. The next vector, a single beat of 5 with last -> out_sum=5, out_ovf=0, out_cnt=1.
- A result is held with out_ready=0 for 10 cycles while in_valid=1 -> in_ready=0 throughout and outputs stable. out_ready=1 -> out_valid=0 the next cycle and the held beat is accepted the cycle after.
- clr pulsed after 4 beats of 1000, together with in_valid -> that beat is dropped. The next vector of 3 beats of 1 -> out_sum=3, out_cnt=3.
- rst_n asserted asynchronously mid-vector and in HOLD -> all outputs drop to their reset values immediately. After release, a one-term vector of -1 -> out_sum=0xFFFFFFFF.
